core_seq_ctrl: RTL and testbench
================================

Name: core_seq_ctrl

Overview:
- Multi-cycle sequencer for the single-issue RV64 core datapath. It replaces the free-running phase counter.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB according to its opcode class.
- Generates the PC load, IR load, register-file write and data-memory strobes, and waits on instruction-memory and data-memory acknowledges.
- Provides run/halt control and a retired-instruction counter.

Parameters:
INSTRET_W, 32, width of retired-instruction counter (wraps modulo 2^INSTRET_W)

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
run  input  1  level; permits fetching of new instructions
halt_req  input  1  level; stop at next instruction boundary
opcode  input  7  inst_reg[6:0] from datapath IR
imem_ack  input  1  instruction memory has valid inst this cycle
dmem_ack  input  1  data memory access complete this cycle
imem_req  output  1  instruction fetch request
ir_load  output  1  load IR from instruction memory
pc_load  output  1  update PC with pc_next (datapath selects branch/inc)
rf_w_en  output  1  register file write enable
dmem_r_en  output  1  data memory read strobe
dmem_w_en  output  1  data memory write strobe
illegal  output  1  one-cycle pulse: unsupported opcode skipped
halted  output  1  sequencer in HALT
state  output  3  current state encoding (debug)
instret  output  INSTRET_W  retired-instruction count

Behaviour:
- Reset: clk, with rstn asynchronous active-low. During reset, state=IDLE, class register=ALU, instret=0. All outputs are 0.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Code 7 is unreachable and recovers to IDLE.
- State and class register are registered. Strobes are combinational from registered state, class register and ack inputs. Strobes are glitch-free relative to clk.
- Opcode classes:
  - ALU: 0110011 and 0010011
  - LOAD: 0000011
  - STORE: 0100011
  - BRANCH: 1100011
  - All other values are ILLEGAL.
- IDLE: all strobes 0. Go to FETCH when run=1, else stay in IDLE.
- FETCH:
  - imem_req=1.
  - If imem_ack=1: ir_load=1 this cycle and go to DECODE.
  - Otherwise stay in FETCH indefinitely with no timeout.
- DECODE:
  - Sample opcode into the class register.
  - If ILLEGAL: illegal=1 and pc_load=1 this cycle, instret is NOT incremented, then go to boundary.
  - Otherwise go to EXEC.
- EXEC: the ALU result and zero are valid in this cycle.
  - BRANCH: pc_load=1, retire, then go to boundary.
  - LOAD or STORE: go to MEM.
  - ALU: go to WB.
- MEM:
  - dmem_r_en=1 for LOAD, dmem_w_en=1 for STORE. The strobe is held until dmem_ack=1.
  - On ack with LOAD: go to WB.
  - On ack with STORE: pc_load=1, retire, then go to boundary.
- WB: rf_w_en=1 and pc_load=1 for exactly one cycle, retire, then go to boundary.
- Boundary decision, taken in the cycle pc_load=1:
  - halt_req=1: go to HALT.
  - Else run=0: go to IDLE.
  - Else: go to FETCH.
- HALT: halted=1 and all strobes 0. Go to FETCH when halt_req=0 and run=1. Go to IDLE when halt_req=0 and run=0.
- Retire: instret increments by 1 in the retire cycle and wraps from all-ones to 0.
- Latency with zero-wait acks, from entering FETCH to pc_load:
  - ALU: 4 cycles
  - LOAD: 5 cycles
  - STORE: 4 cycles
  - BRANCH: 3 cycles
  - ILLEGAL: 2 cycles
- Invariants:
  - pc_load is exactly one pulse per instruction.
  - rf_w_en is never asserted for STORE, BRANCH or ILLEGAL.
  - dmem_r_en and dmem_w_en are never both 1.
- Simultaneous events and stray inputs:
  - halt_req or run deassertion mid-instruction never aborts the instruction. Both take effect only at the boundary.
  - imem_ack outside FETCH and dmem_ack outside MEM are ignored.
  - opcode changes outside DECODE are ignored, because the class register holds.
- Reset mid-operation: any state returns immediately to IDLE with all strobes 0. instret clears, and no partial write strobe persists.

Test Plan:
- Reset, run=1, acks tied high, opcode=0110011 → states 1,2,3,5. ir_load in FETCH cycle, rf_w_en+pc_load together in WB. instret=1 after 4 cycles.
- LOAD 0000011 with dmem_ack delayed 3 cycles → dmem_r_en high 4 consecutive cycles, then WB with rf_w_en. STORE 0100011 → dmem_w_en, pc_load on ack cycle, no rf_w_en.
- BRANCH 1100011 → pc_load in EXEC (3rd cycle), no rf_w_en/dmem strobe. Opcode 1111111 → illegal pulse + pc_load in DECODE, instret unchanged.
- Hold imem_ack=0 for 10 cycles → imem_req held, state=FETCH, no other strobe. Ack then DECODE next cycle.
- Assert halt_req during MEM of a LOAD → load completes through WB, then state=HALT, halted=1. Release halt_req with run=1 → FETCH next cycle. Release with run=0 → IDLE.
- Pulse rstn low during MEM with dmem_w_en high → strobe drops asynchronously, state=IDLE, instret=0. Preload instret near all-ones (INSTRET_W=4, retire 16 instructions) → wraps to 0.

Source files
------------

// File: rtl/core_seq_ctrl.sv
// Multi-cycle instruction sequencer for the RV64 core datapath.
// Steps each instruction FETCH/DECODE/EXEC/MEM/WB by opcode class, with run/halt control and a retire counter.
module core_seq_ctrl #(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 run,
  input  logic                 halt_req,
  input  logic [6:0]           opcode,
  input  logic                 imem_ack,
  input  logic                 dmem_ack,
  output logic                 imem_req,
  output logic                 ir_load,
  output logic                 pc_load,
  output logic                 rf_w_en,
  output logic                 dmem_r_en,
  output logic                 dmem_w_en,
  output logic                 illegal,
  output logic                 halted,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_ALU     = 3'd0,
    C_LOAD    = 3'd1,
    C_STORE   = 3'd2,
    C_BRANCH  = 3'd3,
    C_ILLEGAL = 3'd4
  } cls_t;

  state_t               state_q, state_d, bnd_state;
  cls_t                 cls_q, op_cls;
  logic                 retire;
  logic [INSTRET_W-1:0] instret_q;

  always_comb begin
    unique case (opcode)
      7'b0110011, 7'b0010011: op_cls = C_ALU;
      7'b0000011:             op_cls = C_LOAD;
      7'b0100011:             op_cls = C_STORE;
      7'b1100011:             op_cls = C_BRANCH;
      default:                op_cls = C_ILLEGAL;
    endcase
  end

  // Destination at an instruction boundary: halt has priority over run.
  always_comb begin
    if (halt_req)  bnd_state = S_HALT;
    else if (run)  bnd_state = S_FETCH;
    else           bnd_state = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cls_q     <= C_ALU;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= op_cls;
      if (retire) instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    pc_load   = 1'b0;
    rf_w_en   = 1'b0;
    dmem_r_en = 1'b0;
    dmem_w_en = 1'b0;
    illegal   = 1'b0;
    halted    = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Illegal opcodes are skipped here without retiring.
        if (op_cls == C_ILLEGAL) begin
          illegal = 1'b1;
          pc_load = 1'b1;
          state_d = bnd_state;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_BRANCH: begin
            pc_load = 1'b1;
            retire  = 1'b1;
            state_d = bnd_state;
          end
          C_LOAD, C_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (cls_q == C_LOAD) begin
          dmem_r_en = 1'b1;
          if (dmem_ack) state_d = S_WB;
        end else begin
          dmem_w_en = 1'b1;
          if (dmem_ack) begin
            pc_load = 1'b1;
            retire  = 1'b1;
            state_d = bnd_state;
          end
        end
      end
      S_WB: begin
        rf_w_en = 1'b1;
        pc_load = 1'b1;
        retire  = 1'b1;
        state_d = bnd_state;
      end
      S_HALT: begin
        halted = 1'b1;
        if (!halt_req) state_d = run ? S_FETCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Randomized bench for core_seq_ctrl: a per-instruction model expands each instruction
// into its expected cycle trace; stray inputs are randomized wherever they must be ignored.
module tb_core_seq_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       run, halt_req, imem_ack, dmem_ack;
  logic [6:0] opcode;
  logic       imem_req, ir_load, pc_load, rf_w_en, dmem_r_en, dmem_w_en, illegal, halted;
  logic [2:0] state;
  logic [3:0] instret;

  always #5 clk = ~clk;

  core_seq_ctrl #(.INSTRET_W(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .run       (run),
    .halt_req  (halt_req),
    .opcode    (opcode),
    .imem_ack  (imem_ack),
    .dmem_ack  (dmem_ack),
    .imem_req  (imem_req),
    .ir_load   (ir_load),
    .pc_load   (pc_load),
    .rf_w_en   (rf_w_en),
    .dmem_r_en (dmem_r_en),
    .dmem_w_en (dmem_w_en),
    .illegal   (illegal),
    .halted    (halted),
    .state     (state),
    .instret   (instret)
  );

  // Strobe bit positions in the packed expected-strobe vector.
  localparam int B_REQ = 1, B_IR = 2, B_PC = 4, B_RF = 8;
  localparam int B_DR = 16, B_DW = 32, B_ILL = 64, B_HLT = 128;
  localparam int M_IDLE = 0, M_FETCH = 1, M_HALT = 6;

  typedef struct {
    logic       run, hr, ia, da;
    logic [6:0] op;
    logic [2:0] st;
    logic [7:0] strb;
    logic [3:0] cnt;
  } rec_t;

  rec_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cnt   = 0;
  int   mode  = M_IDLE;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 ILLEGAL
  function automatic int classify(input int op);
    case (op)
      'h33, 'h13: return 0;
      'h03:       return 1;
      'h23:       return 2;
      'h63:       return 3;
      default:    return 4;
    endcase
  endfunction

  function automatic int pick_op();
    int v;
    case ($urandom_range(0, 5))
      0: return 'h33;
      1: return 'h13;
      2: return 'h03;
      3: return 'h23;
      4: return 'h63;
      default: begin
        v = int'($urandom_range(0, 127));
        while (classify(v) != 4) v = int'($urandom_range(0, 127));
        return v;
      end
    endcase
  endfunction

  // Negative arguments mean "don't care": the input is randomized.
  task automatic push(input int st, input int strb, input int ia, input int da,
                      input int op, input int hr, input int rn);
    rec_t r;
    r.st   = 3'(st);
    r.strb = 8'(strb);
    r.ia   = (ia < 0) ? 1'($urandom) : 1'(ia);
    r.da   = (da < 0) ? 1'($urandom) : 1'(da);
    r.op   = (op < 0) ? 7'($urandom) : 7'(op);
    r.hr   = (hr < 0) ? 1'($urandom) : 1'(hr);
    r.run  = (rn < 0) ? 1'($urandom) : 1'(rn);
    r.cnt  = 4'(cnt);
    q.push_back(r);
  endtask

  task automatic boundary(input int st, input int strb, input int da, input int op, input bit ret);
    int hr, rn;
    hr = ($urandom_range(0, 3) == 0) ? 1 : 0;
    rn = ($urandom_range(0, 4) != 0) ? 1 : 0;
    push(st, strb, -1, da, op, hr, rn);
    mode = hr ? M_HALT : (rn ? M_FETCH : M_IDLE);
    if (ret) cnt = (cnt + 1) % 16;
  endtask

  task automatic gen_one(input int force_op, input bit stop_in_mem);
    int op, cls, w, rn;
    while (mode != M_FETCH) begin
      if (mode == M_IDLE) begin
        repeat ($urandom_range(0, 2)) push(0, 0, -1, -1, -1, -1, 0);
        push(0, 0, -1, -1, -1, -1, 1);
        mode = M_FETCH;
      end else begin
        repeat ($urandom_range(0, 3)) push(6, B_HLT, -1, -1, -1, 1, -1);
        rn = int'($urandom_range(0, 1));
        push(6, B_HLT, -1, -1, -1, 0, rn);
        mode = rn ? M_FETCH : M_IDLE;
      end
    end
    op  = (force_op >= 0) ? force_op : pick_op();
    cls = classify(op);
    w   = ($urandom_range(0, 7) == 0) ? 10 : int'($urandom_range(0, 2));
    repeat (w) push(1, B_REQ, 0, -1, -1, -1, -1);
    push(1, B_REQ | B_IR, 1, -1, -1, -1, -1);
    if (cls == 4) begin
      boundary(2, B_ILL | B_PC, -1, op, 1'b0);
      return;
    end
    push(2, 0, -1, -1, op, -1, -1);
    if (cls == 3) begin
      boundary(3, B_PC, -1, -1, 1'b1);
      return;
    end
    push(3, 0, -1, -1, -1, -1, -1);
    if (cls == 0) begin
      boundary(5, B_RF | B_PC, -1, -1, 1'b1);
      return;
    end
    if (stop_in_mem) begin
      push(4, (cls == 1) ? B_DR : B_DW, -1, 0, -1, -1, -1);
      return;
    end
    repeat ($urandom_range(0, 3)) push(4, (cls == 1) ? B_DR : B_DW, -1, 0, -1, -1, -1);
    if (cls == 1) begin
      push(4, B_DR, -1, 1, -1, -1, -1);
      boundary(5, B_RF | B_PC, -1, -1, 1'b1);
    end else begin
      boundary(4, B_DW | B_PC, 1, -1, 1'b1);
    end
  endtask

  task automatic play();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(posedge clk);
      #1;
      run      = r.run;
      halt_req = r.hr;
      opcode   = r.op;
      imem_ack = r.ia;
      dmem_ack = r.da;
      @(negedge clk);
      check("state", 32'(state), 32'(r.st));
      check("strobes", 32'({halted, illegal, dmem_w_en, dmem_r_en, rf_w_en, pc_load, ir_load, imem_req}),
            32'(r.strb));
      check("instret", 32'(instret), 32'(r.cnt));
    end
  endtask

  initial begin
    rstn = 1'b0; run = 1'b1; halt_req = 1'b0; opcode = 7'h33; imem_ack = 1'b1; dmem_ack = 1'b1;
    #12;
    check("rst_state", 32'(state), 32'd0);
    check("rst_strobes", 32'({halted, illegal, dmem_w_en, dmem_r_en, rf_w_en, pc_load, ir_load, imem_req}), 32'd0);
    check("rst_instret", 32'(instret), 32'd0);
    run = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    repeat (60) begin
      gen_one(-1, 1'b0);
      play();
    end

    // Reset asserted while a store holds its write strobe.
    gen_one('h23, 1'b1);
    play();
    #1 rstn = 1'b0;
    #1;
    check("rst_mid_dmem_w_en", 32'(dmem_w_en), 32'd0);
    check("rst_mid_state", 32'(state), 32'd0);
    check("rst_mid_instret", 32'(instret), 32'd0);
    run = 1'b0; halt_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    cnt  = 0;
    mode = M_IDLE;

    repeat (20) begin
      gen_one(-1, 1'b0);
      play();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
